// File: rtl/if_id_stage.sv
// Fetch PC plus IF/ID register; splits the held word into decode fields.
// Stall, flush and redirect come from later stages.
package if_id_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t BUBBLE = '{valid: 1'b0, instr: 32'h0};

endpackage

module if_id_stage
  import if_id_pkg::*;
#(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]      OP_IMM22_A = 4'b1000,
  parameter logic [3:0]      OP_IMM22_B = 4'b1001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [3:0]      id_opcode,
  output logic [5:0]      id_rd,
  output logic [5:0]      id_rs,
  output logic [5:0]      id_rt,
  output logic [31:0]     id_imm_b,
  output logic [31:0]     id_imm_c,
  output logic            id_imm_sel,
  output logic [31:0]     fetch_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_q;
  if_id_t          id_q;
  logic [31:0]     cnt;
  logic            kill;
  logic            load;
  logic            sat;

  assign kill = redirect_valid | flush;
  assign load = !kill && !stall;
  assign sat  = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (!stall) begin
      pc <= pc + 1'b1;
    end
  end

  // A kill still records the current pc so the bubble is traceable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= BUBBLE;
      pc_q <= '0;
    end else if (kill) begin
      id_q <= BUBBLE;
      pc_q <= pc;
    end else if (!stall) begin
      id_q <= '{valid: 1'b1, instr: imem_rdata};
      pc_q <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load && !sat) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    id_imm_sel = 1'b0;
    unique case (id_q.instr[31:28])
      OP_IMM22_A,
      OP_IMM22_B: id_imm_sel = 1'b1;
      default:    id_imm_sel = 1'b0;
    endcase
  end

  assign imem_addr   = pc;
  assign id_valid    = id_q.valid;
  assign id_pc       = pc_q;
  assign id_instr    = id_q.instr;
  assign id_opcode   = id_q.instr[31:28];
  assign id_rd       = id_q.instr[27:22];
  assign id_rs       = id_q.instr[21:16];
  assign id_rt       = id_q.instr[15:10];
  assign id_imm_b    = {16'b0, id_q.instr[15:0]};
  assign id_imm_c    = {10'b0, id_q.instr[21:0]};
  assign fetch_count = cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomised bench for if_id_stage against a small fetch model.
// Directed opening sequence pins the model with literal values.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [3:0]  id_opcode;
  logic [5:0]  id_rd, id_rs, id_rt;
  logic [31:0] id_imm_b, id_imm_c;
  logic        id_imm_sel;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [256];

  // model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[7:0]];

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm_b(id_imm_b), .id_imm_c(id_imm_c), .id_imm_sel(id_imm_sel),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] fetched;
    logic [31:0] cur;
    fetched = imem[m_pc[7:0]];
    cur = m_pc;
    if (redirect_valid) m_pc = redirect_target;
    else if (!stall) m_pc = m_pc + 1;
    if (redirect_valid || flush) begin
      m_instr = 0; m_valid = 0; m_ipc = cur;
    end else if (!stall) begin
      m_instr = fetched; m_valid = 1; m_ipc = cur;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic compare_all();
    logic [3:0] op;
    op = m_instr[31:28];
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    chk("id_pc", id_pc, m_ipc);
    chk("id_instr", id_instr, m_instr);
    chk("id_opcode", {28'b0, id_opcode}, {28'b0, op});
    chk("id_rd", {26'b0, id_rd}, {26'b0, m_instr[27:22]});
    chk("id_rs", {26'b0, id_rs}, {26'b0, m_instr[21:16]});
    chk("id_rt", {26'b0, id_rt}, {26'b0, m_instr[15:10]});
    chk("id_imm_b", id_imm_b, m_instr & 32'h0000_FFFF);
    chk("id_imm_c", id_imm_c, m_instr & 32'h003F_FFFF);
    chk("id_imm_sel", {31'b0, id_imm_sel},
        {31'b0, (op == 4'd8 || op == 4'd9)});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // one clock with current inputs; compares #1 after the edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic s, input logic f, input logic r,
                       input logic [31:0] t);
    stall = s; flush = f; redirect_valid = r; redirect_target = t;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h1040_0001;
    imem[1] = 32'h8000_0123;
    imem[2] = 32'h0000_0000;
    imem[3] = 32'h2FFF_8000;
    imem[8'h40] = 32'h9123_4567;

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #2;
    compare_all();
    chk("reset_fc", fetch_count, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    cycle();
    chk("c1_instr", id_instr, 32'h1040_0001);
    chk("c1_pc", id_pc, 32'h0);
    chk("c1_valid", {31'b0, id_valid}, 32'h1);
    chk("c1_sel", {31'b0, id_imm_sel}, 32'h0);
    cycle();
    chk("c2_immc", id_imm_c, 32'h0000_0123);
    chk("c2_sel", {31'b0, id_imm_sel}, 32'h1);
    cycle();
    cycle();
    chk("c4_fc", fetch_count, 32'd4);
    chk("c4_addr", imem_addr, 32'd4);

    drive(1, 0, 0, 0);
    repeat (3) cycle();
    chk("st_instr", id_instr, 32'h2FFF_8000);
    chk("st_immb", id_imm_b, 32'h0000_8000);
    chk("st_addr", imem_addr, 32'd4);
    chk("st_fc", fetch_count, 32'd4);

    drive(1, 0, 1, 32'h40);
    cycle();
    chk("rd_addr", imem_addr, 32'h40);
    chk("rd_valid", {31'b0, id_valid}, 32'h0);
    chk("rd_instr", id_instr, 32'h0);
    drive(0, 0, 0, 0);
    cycle();
    chk("rd_load", id_instr, 32'h9123_4567);
    chk("rd_pc", id_pc, 32'h40);
    chk("rd_fc", fetch_count, 32'd5);

    drive(0, 1, 0, 0);
    cycle();
    chk("fl_valid", {31'b0, id_valid}, 32'h0);
    chk("fl_addr", imem_addr, 32'h42);
    chk("fl_fc", fetch_count, 32'd5);

    drive(0, 0, 1, 32'hFFFF_FFFF);
    cycle();
    chk("wr_top", imem_addr, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0);
    cycle();
    chk("wr_zero", imem_addr, 32'h0);
    cycle();

    mid_reset();
    cycle();
    chk("post_rst_pc", id_pc, 32'h0);
    chk("post_rst_instr", id_instr, 32'h1040_0001);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                      : $urandom_range(0, 255);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, t);
      cycle();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch PC and IF/ID pipeline register. Sits directly upstream of the immediate-generation mux in the decode stage.
- Holds the program counter and drives the instruction-memory address. Captures the fetched word and splits it into decode fields.
- Presents the 16-bit and 22-bit immediate fields, plus the select that chooses between them, to the immediate generator.
- Supports stall, flush and branch/jump redirect from later stages, and keeps a saturating fetch counter for debug.

Parameters:
PC_W, 32, program counter width in bits; the PC is a word address.
RESET_PC, 0, PC value loaded on reset.
OP_IMM22_A, 4'b1000, first opcode that uses the 22-bit immediate.
OP_IMM22_B, 4'b1001, second opcode that uses the 22-bit immediate.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
stall  in  1  hold the PC and the IF/ID register.
flush  in  1  turn the IF/ID contents into a bubble.
redirect_valid  in  1  load the PC from redirect_target.
redirect_target  in  PC_W  new PC on redirect.
imem_addr  out  PC_W  instruction-memory address; always equals the current PC.
imem_rdata  in  32  instruction word; combinational read of imem_addr.
id_valid  out  1  IF/ID holds a real instruction.
id_pc  out  PC_W  PC of the instruction held in IF/ID.
id_instr  out  32  raw instruction word held in IF/ID.
id_opcode  out  4  id_instr[31:28].
id_rd  out  6  id_instr[27:22].
id_rs  out  6  id_instr[21:16].
id_rt  out  6  id_instr[15:10].
id_imm_b  out  32  {16'b0, id_instr[15:0]}; sign bit is bit 15; feeds imm-gen input B.
id_imm_c  out  32  {10'b0, id_instr[21:0]}; sign bit is bit 21; feeds imm-gen input C.
id_imm_sel  out  1  1 when id_opcode is OP_IMM22_A or OP_IMM22_B, else 0; feeds imm-gen sel.
fetch_count  out  32  number of instructions accepted into IF/ID; saturates.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values (rst_n=0, takes effect immediately, no clock needed):
  - pc = RESET_PC.
  - id_valid = 0, id_instr = 0, id_pc = 0, fetch_count = 0.
  - All derived fields are therefore 0, including id_imm_sel.
- Instruction word 32'h0 (opcode 0000) is the NOP/bubble.
- PC update, evaluated in priority order on each rising edge:
  1. redirect_valid=1: pc <= redirect_target.
  2. else stall=1: pc holds.
  3. else: pc <= pc+1, wrapping modulo 2^PC_W; all-ones wraps to 0.
- IF/ID update, evaluated in priority order on each rising edge:
  1. redirect_valid=1 or flush=1: id_instr <= 0, id_valid <= 0, id_pc <= pc. The word fetched this cycle is discarded.
  2. else stall=1: id_instr, id_pc and id_valid hold.
  3. else: id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
- Simultaneous events:
  - Redirect overrides stall, so a redirect during a stall still moves the PC.
  - flush with stall: IF/ID bubbles while the PC holds.
  - flush with redirect: same as redirect alone.
- Latency: the word at address A appears on the id_* outputs 1 cycle after imem_addr=A, provided that cycle is not stalled or flushed.
- Decode fields (id_opcode, id_rd, id_rs, id_rt, id_imm_b, id_imm_c, id_imm_sel) are purely combinational from the id_instr register. No extra latency.
- Immediate fields are not sign-extended here; sign extension belongs to the downstream immediate generator.
- fetch_count:
  - Increments by 1 only in a cycle where IF/ID loads a real instruction (IF/ID case 3).
  - Holds at 32'hFFFFFFFF once reached.
- Reset asserted mid-operation: all state clears immediately. The first fetch after rst_n rises comes from RESET_PC.

Test Plan:
- Reset then free-run; imem[0..3] = 32'h10400001, 32'h80000123, 32'h00000000, 32'h2FFF8000 -> imem_addr steps 0,1,2,3.
  - Cycle 1: id_instr=32'h10400001, id_pc=0, id_valid=1, id_imm_sel=0.
  - Next cycle: id_imm_c=32'h00000123, id_imm_sel=1.
  - fetch_count=4 after 4 cycles.
- Stall for 3 cycles while id_instr=32'h2FFF8000 -> PC, id_instr and fetch_count all hold; id_imm_b=32'h00008000.
- redirect_valid=1 with target 32'h40 while stall=1 -> next cycle: imem_addr=32'h40, id_valid=0, id_instr=0. The cycle after, the instruction from address 32'h40 loads.
- flush=1 for one cycle with no stall -> id_valid=0 for one cycle; PC still advances by 1; fetch_count does not increment.
- Force pc to all-ones (redirect to 32'hFFFFFFFF), then run -> imem_addr wraps to 0 on the following cycle.
- Assert rst_n=0 between clock edges mid-run -> all outputs reach their reset values before the next edge; after release, imem_addr=RESET_PC.
